// File: rtl/mem_loader.sv
// Byte-serial loader for the second write port of a data memory.
// Bytes arrive MSB-first from a switch bank, are packed into 32-bit words and
// written at an auto-incrementing word address. An address strobe reloads the
// write address from the same byte input.
module mem_loader #(
  parameter int unsigned       ADDR_W   = 9,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 9'h1FF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        din,
  input  logic              din_stb,
  input  logic              addr_stb,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        byte_idx,
  output logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              full,
  output logic              drop_err
);

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StWrite,
    StFull
  } state_e;

  state_e      state_q;
  // Upper three bytes of the word being assembled; the fourth byte comes
  // straight from din when the word completes.
  logic [23:0] asm_q;

  // The write strobe is the pending-write flag itself.
  assign busy = mem_we;

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      asm_q      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      byte_idx   <= '0;
      word_count <= '0;
      full       <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StCollect: begin
          if (addr_stb) begin
            // Address load wins over a simultaneous data byte.
            mem_addr   <= ADDR_W'(din);
            byte_idx   <= '0;
            word_count <= '0;
            full       <= 1'b0;
            asm_q      <= '0;
            state_q    <= StIdle;
            if (din_stb) begin
              drop_err <= 1'b1;
            end
          end else if (din_stb) begin
            asm_q <= {asm_q[15:0], din};
            if (byte_idx == 2'd3) begin
              mem_wdata <= {asm_q, din};
              byte_idx  <= '0;
              mem_we    <= 1'b1;
              state_q   <= StWrite;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              state_q  <= StCollect;
            end
          end
        end

        StWrite: begin
          // Strobes cannot disturb a pending write; they only flag the loss.
          if (din_stb || addr_stb) begin
            drop_err <= 1'b1;
          end
          if (mem_ready) begin
            mem_we     <= 1'b0;
            word_count <= word_count + ADDR_W'(1);
            if (mem_addr == MAX_ADDR) begin
              full    <= 1'b1;
              state_q <= StFull;
            end else begin
              mem_addr <= mem_addr + ADDR_W'(1);
              state_q  <= StIdle;
            end
          end
        end

        StFull: begin
          if (addr_stb) begin
            mem_addr   <= ADDR_W'(din);
            byte_idx   <= '0;
            word_count <= '0;
            full       <= 1'b0;
            asm_q      <= '0;
            state_q    <= StIdle;
            if (din_stb) begin
              drop_err <= 1'b1;
            end
          end else if (din_stb) begin
            drop_err <= 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: two instances (default MAX_ADDR and MAX_ADDR=3) share
// one stimulus stream; a behavioural model is checked every cycle, and the
// directed scenarios also pin literal values.
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_stb;
  logic       addr_stb;
  logic       mem_ready;

  logic        we0, we1, busy0, busy1, full0, full1, drop0, drop1;
  logic [8:0]  addr0, addr1, cnt0, cnt1;
  logic [31:0] wd0, wd1;
  logic [1:0]  bi0, bi1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_loader u_dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_stb    (din_stb),
    .addr_stb   (addr_stb),
    .mem_ready  (mem_ready),
    .mem_we     (we0),
    .mem_addr   (addr0),
    .mem_wdata  (wd0),
    .byte_idx   (bi0),
    .word_count (cnt0),
    .busy       (busy0),
    .full       (full0),
    .drop_err   (drop0)
  );

  mem_loader #(
    .ADDR_W   (9),
    .MAX_ADDR (9'h003)
  ) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_stb    (din_stb),
    .addr_stb   (addr_stb),
    .mem_ready  (mem_ready),
    .mem_we     (we1),
    .mem_addr   (addr1),
    .mem_wdata  (wd1),
    .byte_idx   (bi1),
    .word_count (cnt1),
    .busy       (busy1),
    .full       (full1),
    .drop_err   (drop1)
  );

  // Behavioural model: a byte counter, a pending-write flag and plain integers.
  logic [8:0]  m_max [2] = '{9'h1FF, 9'h003};
  logic        m_pend [2];
  logic [8:0]  m_addr [2];
  logic [8:0]  m_cnt [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_word [2];
  int          m_n [2];
  logic        m_full [2];
  logic        m_drop [2];
  logic        checking = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pend[k] = 1'b0; m_addr[k] = '0; m_cnt[k] = '0; m_wdata[k] = '0;
        m_word[k] = '0; m_n[k] = 0; m_full[k] = 1'b0; m_drop[k] = 1'b0;
      end else if (m_pend[k]) begin
        if (din_stb || addr_stb) m_drop[k] = 1'b1;
        if (mem_ready) begin
          m_pend[k] = 1'b0;
          m_cnt[k]  = m_cnt[k] + 9'd1;
          if (m_addr[k] == m_max[k]) m_full[k] = 1'b1;
          else m_addr[k] = m_addr[k] + 9'd1;
        end
      end else if (addr_stb) begin
        m_addr[k] = {1'b0, din};
        m_n[k] = 0; m_word[k] = '0; m_cnt[k] = '0; m_full[k] = 1'b0;
        if (din_stb) m_drop[k] = 1'b1;
      end else if (m_full[k]) begin
        if (din_stb) m_drop[k] = 1'b1;
      end else if (din_stb) begin
        m_word[k] = (m_word[k] << 8) | {24'd0, din};
        m_n[k] = m_n[k] + 1;
        if (m_n[k] == 4) begin
          m_wdata[k] = m_word[k];
          m_pend[k]  = 1'b1;
          m_n[k]     = 0;
        end
      end
    end
    if (rst) checking = 1'b1;
  end

  task automatic cmp(input int k, input logic we, input logic [8:0] addr,
                     input logic [31:0] wd, input logic [1:0] bi, input logic [8:0] cnt,
                     input logic busy, input logic full, input logic drop);
    tests++;
    if (we !== m_pend[k] || addr !== m_addr[k] || wd !== m_wdata[k] ||
        bi !== 2'(m_n[k]) || cnt !== m_cnt[k] || busy !== m_pend[k] ||
        full !== m_full[k] || drop !== m_drop[k]) begin
      fails++;
      $display("FAIL model dut%0d t=%0t got we=%b addr=%h wd=%h bi=%0d cnt=%h busy=%b full=%b drop=%b want we=%b addr=%h wd=%h bi=%0d cnt=%h full=%b drop=%b",
               k, $time, we, addr, wd, bi, cnt, busy, full, drop, m_pend[k], m_addr[k],
               m_wdata[k], m_n[k], m_cnt[k], m_full[k], m_drop[k]);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (checking) begin
      cmp(0, we0, addr0, wd0, bi0, cnt0, busy0, full0, drop0);
      cmp(1, we1, addr1, wd1, bi1, cnt1, busy1, full1, drop1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(input logic r, input logic [7:0] d, input logic ds, input logic as,
                      input logic rdy);
    rst = r; din = d; din_stb = ds; addr_stb = as; mem_ready = rdy;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input logic rdy);
    for (int i = 0; i < 4; i++) tick(1'b0, w[31-8*i -: 8], 1'b1, 1'b0, rdy);
  endtask

  initial begin
    logic       r, ds, as, rdy;
    logic [7:0] d;

    tick(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'h55, 1'b1, 1'b1, 1'b1);  // reset beats strobes
    chk("reset_we", {31'd0, we0}, 32'd0);
    chk("reset_addr", {23'd0, addr0}, 32'd0);
    chk("reset_drop", {31'd0, drop0}, 32'd0);

    // Basic word at address 0 with mem_ready tied high.
    send_word(32'h12345678, 1'b1);
    chk("w1_we", {31'd0, we0}, 32'd1);
    chk("w1_addr", {23'd0, addr0}, 32'd0);
    chk("w1_wdata", wd0, 32'h12345678);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("w1_done_we", {31'd0, we0}, 32'd0);
    chk("w1_next_addr", {23'd0, addr0}, 32'd1);
    chk("w1_count", {23'd0, cnt0}, 32'd1);

    // Stalled write at 0x010 with a dropped byte during the stall.
    tick(1'b0, 8'h10, 1'b0, 1'b1, 1'b0);
    send_word(32'h01020304, 1'b0);
    tick(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("stall_we", {31'd0, we0}, 32'd1);
    chk("stall_addr", {23'd0, addr0}, 32'h010);
    chk("stall_wdata", wd0, 32'h01020304);
    chk("stall_drop", {31'd0, drop0}, 32'd1);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("stall_done_we", {31'd0, we0}, 32'd0);
    chk("stall_next_addr", {23'd0, addr0}, 32'h011);

    // Partial word discarded by an address load.
    tick(1'b0, 8'h11, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 8'h22, 1'b1, 1'b0, 1'b1);
    chk("partial_bidx", {30'd0, bi0}, 32'd2);
    tick(1'b0, 8'h05, 1'b0, 1'b1, 1'b1);
    send_word(32'hAABBCCDD, 1'b1);
    chk("reload_addr", {23'd0, addr0}, 32'h005);
    chk("reload_wdata", wd0, 32'hAABBCCDD);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Fill the MAX_ADDR=3 instance.
    tick(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h03, 1'b0, 1'b1, 1'b0);
    send_word(32'hCAFEF00D, 1'b1);
    chk("full_we", {31'd0, we1}, 32'd1);
    chk("full_waddr", {23'd0, addr1}, 32'd3);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("full_flag", {31'd0, full1}, 32'd1);
    chk("full_hold_addr", {23'd0, addr1}, 32'd3);
    send_word(32'h01020304, 1'b1);
    chk("full_no_we", {31'd0, we1}, 32'd0);
    chk("full_drop", {31'd0, drop1}, 32'd1);
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("full_clear", {31'd0, full1}, 32'd0);

    // Reset during a stalled write abandons it.
    send_word(32'h0BADBEEF, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_write_we", {31'd0, we0}, 32'd0);
    chk("rst_write_wdata", wd0, 32'd0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("rst_write_we2", {31'd0, we0}, 32'd0);

    // Simultaneous strobes.
    tick(1'b0, 8'h20, 1'b1, 1'b1, 1'b1);
    chk("both_addr", {23'd0, addr0}, 32'h020);
    chk("both_bidx", {30'd0, bi0}, 32'd0);
    chk("both_drop", {31'd0, drop0}, 32'd1);

    // Random traffic checked by the model.
    for (int n = 0; n < 5000; n++) begin
      r   = ($urandom_range(0, 199) == 0);
      ds  = ($urandom_range(0, 9) < 4);
      as  = ($urandom_range(0, 24) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      d   = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom);
      tick(r, d, ds, as, rdy);
    end

    tick(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, defining the word-address width of the data-memory write port.
REQ-002 The block SHALL have parameter MAX_ADDR, default 9'h1FF, defining the last writable word address.
REQ-003 clk  input  1  system clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 din  input  8  byte value from the switch bank.
REQ-006 din_stb  input  1  single-cycle pulse that accepts din as the next data byte.
REQ-007 addr_stb  input  1  single-cycle pulse that loads the write address from din.
REQ-008 mem_ready  input  1  memory accepts the current write in this cycle.
REQ-009 mem_we  output  1  write enable for the data-memory second port.
REQ-010 mem_addr  output  ADDR_W  word address for the write.
REQ-011 mem_wdata  output  32  word to be written.
REQ-012 byte_idx  output  2  number of bytes collected toward the current word.
REQ-013 word_count  output  ADDR_W  number of words written since the last address load.
REQ-014 busy  output  1  high while a write is pending.
REQ-015 full  output  1  high once MAX_ADDR has been written.
REQ-016 drop_err  output  1  sticky flag indicating that a strobe was ignored.

Function
REQ-017 The FSM SHALL have the states IDLE, COLLECT, WRITE and FULL.
REQ-018 In IDLE, a din_stb SHALL store the byte, set byte_idx to 1 and move the FSM to COLLECT.
REQ-019 Bytes SHALL be assembled MSB-first: each accepted byte shifts the word assembly register left by 8 bits and enters at bits [7:0].
REQ-020 On the 4th accepted byte (byte_idx=3 plus din_stb), the FSM SHALL move to WRITE, clear byte_idx to 0, and register the completed word into mem_wdata.
REQ-021 In WRITE, mem_we SHALL be 1, and mem_addr and mem_wdata SHALL be held stable; busy SHALL equal mem_we.
REQ-022 Latency: mem_we SHALL rise in the cycle following the 4th din_stb.
REQ-023 mem_we SHALL stay high until mem_ready is sampled high in the same cycle; a write completes in 1 cycle when mem_ready is tied high.
REQ-024 On completion, word_count SHALL increment by 1 and mem_we SHALL drop in the next cycle.
REQ-025 On completion, if mem_addr is not equal to MAX_ADDR, mem_addr SHALL increment by 1 and the FSM SHALL return to IDLE.
REQ-026 On completion, if mem_addr equals MAX_ADDR, mem_addr SHALL hold, full SHALL be set to 1, and the FSM SHALL enter FULL.
REQ-027 In FULL, din_stb SHALL be ignored and SHALL set drop_err; only addr_stb or rst SHALL leave FULL.
REQ-028 addr_stb in IDLE, COLLECT or FULL SHALL:
- load mem_addr = din zero-extended to ADDR_W;
- clear byte_idx, word_count and full;
- discard any partial word;
- move the FSM to IDLE.
REQ-029 addr_stb and din_stb in the same cycle: addr_stb SHALL win, and the byte SHALL be dropped with drop_err set.
REQ-030 din_stb or addr_stb during WRITE SHALL be ignored and SHALL set drop_err; the pending write SHALL be unaffected.
REQ-031 drop_err SHALL be cleared only by rst.
REQ-032 Word-count arithmetic SHALL be modulo 2^ADDR_W; word_count SHALL not exceed MAX_ADDR+1 in normal use.

Reset
REQ-033 While rst=1, all outputs and state SHALL be 0, the FSM SHALL be in IDLE, and any pending write SHALL be abandoned (mem_we=0 in the cycle after rst is sampled).
REQ-034 Reset SHALL take priority over all strobes in the same cycle.

Verification
REQ-035 rst, then din_stb with 12,34,56,78 and mem_ready=1 -> one cycle with mem_we=1, mem_addr=0, mem_wdata=32'h12345678; then mem_addr=1, word_count=1.
REQ-036 addr_stb with din=8'h10, then 4 bytes with mem_ready=0 for 3 cycles -> mem_we high for 4 cycles, write to address 0x010; a din_stb during the stall sets drop_err, and the data is unchanged.
REQ-037 2 bytes, then addr_stb with din=8'h05, then 4 bytes AA,BB,CC,DD -> single write of 32'hAABBCCDD at 0x005; the partial word is lost.
REQ-038 MAX_ADDR=9'h003, addr_stb with din=3, then 4 bytes -> write at 3, full=1; further din_stb -> no mem_we, drop_err=1; addr_stb -> full=0.
REQ-039 rst asserted during WRITE with mem_ready=0 -> mem_we=0 next cycle; all outputs are 0 and no write occurs.
REQ-040 addr_stb and din_stb in the same cycle with din=8'h20 -> mem_addr=0x020, byte_idx=0, drop_err=1.
